// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types for the commit-stage data port and its SRAM responder.
// Request/response structs plus the upper bound on response latency.
package dbus_sram_responder_pkg;

    localparam int DBUS_MAX_LATENCY = 8;

    typedef struct packed {
        logic        req;
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  write_en;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_bram.sv
// Single-port synchronous SRAM, 32-bit words with byte write enables.
// Read data appears one cycle after an enabled access; contents are never reset.
module dbus_bram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by on-chip SRAM: accepts when req and not stalled,
// returns in-order data_ok exactly LATENCY cycles after accept, no response backpressure.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dmem_req,
    output dbus_resp_t dmem_resp,
    input  logic       stall_in,
    output logic       busy
);

    logic        accept;
    logic [31:0] bram_rdata;
    logic [31:0] last_rdata;

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [LATENCY-1:0] wr_q, wr_d;

    // reset gates acceptance, which also blocks any SRAM write while in reset
    assign accept = dmem_req.req & ~stall_in & reset;

    dbus_bram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
        .clk   (clk),
        .en    (accept),
        .we    (dmem_req.is_write ? dmem_req.write_en : 4'b0000),
        .addr  (dmem_req.addr[ADDR_WIDTH+1:2]),
        .wdata (dmem_req.data),
        .rdata (bram_rdata)
    );

    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_req.addr[31:ADDR_WIDTH+2], dmem_req.addr[1:0]};

    always_comb begin
        valid_d = '0;
        wr_d    = '0;
        if (reset) begin
            valid_d[0] = accept;
            wr_d[0]    = dmem_req.is_write;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                wr_d[i]    = wr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        wr_q    <= wr_d;
    end

    // Read data joins the pipe at stage 1, the first cycle the SRAM output is valid.
    generate
        if (LATENCY == 1) begin : g_direct
            assign last_rdata = bram_rdata;
        end else begin : g_rdpipe
            logic [31:0] rdata_q [1:LATENCY-1];
            logic [31:0] rdata_d [1:LATENCY-1];

            always_comb begin
                rdata_d[1] = bram_rdata;
                for (int i = 2; i < LATENCY; i++) begin
                    rdata_d[i] = rdata_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                rdata_q <= rdata_d;
            end

            assign last_rdata = rdata_q[LATENCY-1];
        end
    endgenerate

    assign dmem_resp.addr_ok = accept;
    assign dmem_resp.data_ok = valid_q[LATENCY-1];
    assign dmem_resp.data    = (valid_q[LATENCY-1] & ~wr_q[LATENCY-1]) ? last_rdata : 32'h0;
    assign busy              = |valid_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Drives three responders (LATENCY 1, 2, 3) with identical traffic and checks each
// cycle against a transaction-level model of accepts, memory contents and due cycles.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  req;
    logic       stall;
    dbus_resp_t resp1, resp2, resp3;
    logic       busy1, busy2, busy3;

    always #5 clk = ~clk;

    dbus_sram_responder #(.ADDR_WIDTH(12), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .dmem_req(req), .dmem_resp(resp1), .stall_in(stall), .busy(busy1));
    dbus_sram_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .dmem_req(req), .dmem_resp(resp2), .stall_in(stall), .busy(busy2));
    dbus_sram_responder #(.ADDR_WIDTH(12), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .dmem_req(req), .dmem_resp(resp3), .stall_in(stall), .busy(busy3));

    typedef struct {
        int          t;
        bit          known;
        logic [31:0] data;
        bit   [2:0]  alive;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem [int];
    bit   [3:0]  kn  [int];
    logic [31:0] seen3[$];
    logic [31:0] last2, last3;
    int          lat [3] = '{1, 2, 3};
    int          cyc, tests, fails;
    bit          hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic dbus_resp_t get_resp(input int k);
        return (k == 0) ? resp1 : (k == 1) ? resp2 : resp3;
    endfunction

    function automatic logic get_busy(input int k);
        return (k == 0) ? busy1 : (k == 1) ? busy2 : busy3;
    endfunction

    task automatic drive(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] we);
        req.req      = r;
        req.is_write = w;
        req.addr     = a;
        req.data     = d;
        req.write_en = we;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // One bus cycle: check outputs mid-cycle, then advance the model to the next edge.
    task automatic tick();
        bit   acc;
        int   idx;
        ent_t e;
        @(negedge clk);
        acc = req.req && !stall && reset;
        for (int k = 0; k < 3; k++) begin
            dbus_resp_t  r;
            bit          exp_ok, exp_busy, exp_known;
            logic [31:0] exp_data;
            r = get_resp(k);
            exp_ok = 0; exp_busy = 0; exp_known = 0; exp_data = 32'h0;
            foreach (q[j]) begin
                if (q[j].alive[k]) begin
                    if (q[j].t + lat[k] == cyc) begin
                        exp_ok    = 1;
                        exp_known = q[j].known;
                        exp_data  = q[j].data;
                    end
                    if (q[j].t + lat[k] >= cyc) exp_busy = 1;
                end
            end
            check($sformatf("addr_ok_L%0d", lat[k]), {31'b0, r.addr_ok}, {31'b0, acc});
            check($sformatf("data_ok_L%0d", lat[k]), {31'b0, r.data_ok}, {31'b0, exp_ok});
            check($sformatf("busy_L%0d", lat[k]), {31'b0, get_busy(k)}, {31'b0, exp_busy});
            if (exp_ok && exp_known) check($sformatf("rdata_L%0d", lat[k]), r.data, exp_data);
            if (k == 1 && r.data_ok) last2 = r.data;
            if (k == 2 && r.data_ok) begin
                last3 = r.data;
                seen3.push_back(r.data);
            end
        end
        if (!reset) begin
            foreach (q[j])
                for (int k = 0; k < 3; k++)
                    if (q[j].t + lat[k] > cyc) q[j].alive[k] = 0;
        end
        if (acc) begin
            idx = int'((req.addr >> 2) & 32'hFFF);
            e.t = cyc;
            e.alive = 3'b111;
            if (req.is_write) begin
                if (!mem.exists(idx)) begin
                    mem[idx] = 32'h0;
                    kn[idx]  = 4'h0;
                end
                for (int i = 0; i < 4; i++)
                    if (req.write_en[i]) begin
                        mem[idx][8*i +: 8] = req.data[8*i +: 8];
                        kn[idx][i] = 1'b1;
                    end
                e.known = 1;
                e.data  = 32'h0;
            end else begin
                e.known = mem.exists(idx) && (kn[idx] == 4'hF);
                e.data  = e.known ? mem[idx] : 32'h0;
            end
            q.push_back(e);
        end
        hold = req.req && !acc;
        while (q.size() > 0 && q[0].t + 3 < cyc) void'(q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; hold = 0;
        last2 = 32'h0; last3 = 32'h0;
        reset = 1'b0; stall = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #3;
        check("reset_data_L1", resp1.data, 32'h0);
        check("reset_data_L2", resp2.data, 32'h0);
        check("reset_data_L3", resp3.data, 32'h0);
        tick();

        // full write then immediate read-back
        drive(1, 1, 32'h100, 32'hDEADBEEF, 4'hF); tick();
        drive(1, 0, 32'h100, 32'h0, 4'h0);        tick();
        idle(); repeat (4) tick();
        check("t2_read_back", last2, 32'hDEADBEEF);

        // single-lane write, then a write with no lanes enabled
        drive(1, 1, 32'h100, 32'h000000AA, 4'b0001); tick();
        drive(1, 0, 32'h100, 32'h0, 4'h0);           tick();
        idle(); repeat (3) tick();
        check("t3_partial", last2, 32'hDEADBEAA);
        drive(1, 1, 32'h100, 32'hFFFFFFFF, 4'b0000); tick();
        drive(1, 0, 32'h100, 32'h0, 4'h0);           tick();
        idle(); repeat (3) tick();
        check("t3_noop_write", last2, 32'hDEADBEAA);

        // request held under stall
        drive(1, 1, 32'h200, 32'h12345678, 4'hF); tick();
        drive(1, 0, 32'h200, 32'h0, 4'h0);
        stall = 1'b1; repeat (3) tick();
        stall = 1'b0; tick();
        idle(); repeat (4) tick();
        check("t4_stalled_read", last2, 32'h12345678);

        // preload 0..7, then eight back-to-back reads
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 32'(i * 4), 32'(i), 4'hF); tick();
        end
        idle(); repeat (4) tick();
        seen3.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'(i * 4), 32'h0, 4'h0); tick();
        end
        idle(); repeat (5) tick();
        check("t5_count", 32'(seen3.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen3.size(); i++)
            check($sformatf("t5_order_%0d", i), seen3[i], 32'(i));

        // reset while a read is in flight
        drive(1, 1, 32'h300, 32'hCAFEF00D, 4'hF); tick();
        idle(); repeat (4) tick();
        drive(1, 0, 32'h300, 32'h0, 4'h0); tick();
        idle(); reset = 1'b0; tick();
        reset = 1'b1; repeat (5) tick();
        drive(1, 0, 32'h300, 32'h0, 4'h0); tick();
        idle(); repeat (4) tick();
        check("t6_after_reset", last3, 32'hCAFEF00D);

        // randomized traffic with aliasing upper address bits
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                logic [31:0] a;
                a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
                drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a,
                      $urandom, 4'($urandom));
            end
            stall = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 49) != 0);
            tick();
        end
        reset = 1'b1; stall = 1'b0; idle();
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
Slave (responder) end of the data bus used by the commit stage. It accepts dbus_req_t requests with an addr_ok handshake and services them from on-chip byte-writable SRAM. It returns in-order data_ok pulses, with read data, after a fixed, parameterised latency. It is the bench and FPGA-bringup memory model for the dual-issue core's data port, replacing the external cache/AXI path.

Parameters:
ADDR_WIDTH, 12, log2 of SRAM depth in 32-bit words; word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing).
LATENCY, 2, cycles from the accept edge to the data_ok cycle; legal range 1..8.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
dmem_req  in  dbus_req_t (req 1, is_write 1, addr 32, data 32, write_en 4)  request from initiator
dmem_resp  out  dbus_resp_t (addr_ok 1, data_ok 1, data 32)  response to initiator
stall_in  in  1  verification throttle; while 1, addr_ok is forced to 0
busy  out  1  at least one accepted request has not yet returned data_ok

Behaviour:
- Accept rule (combinational): addr_ok = dmem_req.req & ~stall_in & reset.
- A request is accepted in any cycle where req & addr_ok is true. At most one request is accepted per cycle. The initiator holds req, addr, data, write_en and is_write stable until addr_ok.
- Write, on accept: at the clock edge, SRAM byte lanes i with write_en[i]=1 take data[8i+7:8i]. write_en=0 is a legal no-op write and still produces a data_ok.
- Read, on accept: synchronous read of the addressed word at the same edge, so read data is available one cycle after accept. A read accepted in cycle t+1 returns the data written by a write accepted in cycle t to the same word.
- Response pipeline: shift register of LATENCY stages, each stage {valid, is_write, rdata}.
  - Stage 0 is loaded at the accept edge; valid=1 only if accepted.
  - Read data is captured into the stage that the request occupies one cycle after accept.
  - The last stage drives dmem_resp: data_ok = last.valid; data = last.rdata for reads, 0 for writes.
  - LATENCY=1: data_ok is asserted in the cycle after accept, with data driven directly from the SRAM read port.
- Ordering and throughput: responses are strictly in order. Back-to-back accepts yield back-to-back data_ok pulses. There is no response backpressure, and the initiator must always take data_ok.
- busy = OR of all stage valid bits.
- Reset (reset=0 at an edge):
  - all stage valid bits clear, so data_ok=0 and busy=0 from the next cycle;
  - dmem_resp.data resets to 0;
  - a request in flight at reset is dropped with no data_ok;
  - SRAM contents are NOT cleared;
  - no write is performed in a cycle where reset=0.
- Simultaneous events: an accept and a data_ok in the same cycle are independent. stall_in rising while req is held keeps the request pending with no side effects.

Decomposition:
- dbus_req_t and dbus_resp_t remain in data_bus.svh.
- Add DBUS_MAX_LATENCY = 8 to the same header.
- One sub-module: dbus_bram, a single-port synchronous SRAM with 4 byte-write enables and one-cycle read, parameterised by ADDR_WIDTH.
- The handshake and the response pipeline live in the top module.

Test Plan:
1. Reset low for 2 cycles, then high with req=0 -> data_ok=0, busy=0, data=0, addr_ok=0.
2. Write addr 0x100, data 0xDEADBEEF, write_en 4'b1111, then read 0x100 on the next cycle, LATENCY=2 -> data_ok two cycles after each accept; read data = 0xDEADBEEF; consecutive data_ok pulses.
3. Partial write of 0x000000AA with write_en 4'b0001 to 0x100 (holding 0xDEADBEEF), then read -> 0xDEADBEAA. Then write_en=0 with data 0xFFFFFFFF -> still 0xDEADBEAA, and the no-op write gets its data_ok.
4. stall_in=1 for 3 cycles while a read of 0x200 is held -> addr_ok=0 for 3 cycles with no data_ok. Accept happens on the cycle stall_in drops; data_ok follows LATENCY cycles later.
5. Eight back-to-back reads of 0x0..0x1C, preloaded with values 0..7, LATENCY=3 -> eight consecutive data_ok pulses starting 3 cycles after the first accept, returning data 0..7 in order.
6. Reset asserted one cycle after accepting a read, LATENCY=3 -> no data_ok is ever produced for it; busy=0 after reset; a later read of the same word returns its pre-reset contents.
